// File: rtl/if_id_buf.sv
// Fetch-to-decode pipeline buffer: a main entry feeding ID plus a one-entry skid
// register, so if_ready comes straight from a flop instead of depending on id_ready.
module if_id_buf #(
  parameter int                    PC_WIDTH   = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fetch_valid,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  input  logic [INST_WIDTH-1:0] fetch_instr,
  output logic                  if_ready,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [PC_WIDTH-1:0]   ID_pc,
  output logic [INST_WIDTH-1:0] ID_instr,
  output logic                  skid_full
);

  logic                  m_v;
  logic [PC_WIDTH-1:0]   m_pc;
  logic [INST_WIDTH-1:0] m_instr;
  logic                  s_v;
  logic [PC_WIDTH-1:0]   s_pc;
  logic [INST_WIDTH-1:0] s_instr;

  logic acc;
  logic drn;
  logic free;

  assign if_ready  = ~s_v | flush;
  assign if_valid  = m_v;
  assign skid_full = s_v;
  assign ID_pc     = m_v ? m_pc : '0;
  assign ID_instr  = m_v ? m_instr : NOP_INST;

  assign acc  = fetch_valid & if_ready;
  assign drn  = m_v & id_ready;
  assign free = ~m_v | drn;

  // The skid entry is always older than the incoming word, so it refills main first.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_v     <= 1'b0;
      m_pc    <= '0;
      m_instr <= NOP_INST;
      s_v     <= 1'b0;
      s_pc    <= '0;
      s_instr <= NOP_INST;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (free) begin
      if (s_v) begin
        m_v     <= 1'b1;
        m_pc    <= s_pc;
        m_instr <= s_instr;
        if (acc) begin
          s_pc    <= fetch_pc;
          s_instr <= fetch_instr;
        end else begin
          s_v <= 1'b0;
        end
      end else if (acc) begin
        m_v     <= 1'b1;
        m_pc    <= fetch_pc;
        m_instr <= fetch_instr;
      end else begin
        m_v <= 1'b0;
      end
    end else if (acc) begin
      s_v     <= 1'b1;
      s_pc    <= fetch_pc;
      s_instr <= fetch_instr;
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Scoreboard bench for if_id_buf: the reference is an ordered queue of accepted,
// not-yet-consumed words; its length alone predicts valid/ready/skid_full.
module tb_if_id_buf;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } word_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [63:0] fetch_pc = '0;
  logic [31:0] fetch_instr = '0;
  logic        id_ready = 1'b0;
  logic        if_ready;
  logic        if_valid;
  logic [63:0] ID_pc;
  logic [31:0] ID_instr;
  logic        skid_full;

  int    vectors = 0;
  int    miscompares = 0;
  word_t exp_q[$];
  bit    known = 1'b0;
  bit    pend_rst = 1'b0;
  bit    pend_fl = 1'b0;
  bit    pend_acc = 1'b0;
  word_t pend_word;

  if_id_buf #(.PC_WIDTH(64), .INST_WIDTH(32), .NOP_INST(NOP)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr),
    .if_ready(if_ready),
    .id_ready(id_ready),
    .if_valid(if_valid),
    .ID_pc(ID_pc),
    .ID_instr(ID_instr),
    .skid_full(skid_full)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Fold the previous cycle's accept/flush/reset into the reference queue.
  task automatic commit_pending();
    if (pend_rst || pend_fl) begin
      exp_q.delete();
      if (pend_rst) known = 1'b1;
    end else if (pend_acc) begin
      exp_q.push_back(pend_word);
    end
  endtask

  task automatic apply_stimulus(input logic fv, input logic [63:0] pc, input logic [31:0] instr,
                                input logic idr, input logic fl, input logic rst);
    bit ready;
    @(posedge clock);
    #1;
    commit_pending();
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = instr;
    id_ready    = idr;
    flush       = fl;
    reset       = rst;
    ready       = (exp_q.size() < 2) || fl;
    pend_rst    = rst;
    pend_fl     = fl;
    pend_acc    = fv && ready;
    pend_word.pc    = pc;
    pend_word.instr = instr;
  endtask

  task automatic check_output();
    int n;
    n = exp_q.size();
    cmp("if_valid", {63'd0, if_valid}, {63'd0, n > 0});
    cmp("if_ready", {63'd0, if_ready}, {63'd0, (n < 2) || flush});
    cmp("skid_full", {63'd0, skid_full}, {63'd0, n == 2});
    if (n == 0) begin
      cmp("ID_pc_masked", ID_pc, 64'd0);
      cmp("ID_instr_masked", {32'd0, ID_instr}, {32'd0, NOP});
    end else begin
      cmp("ID_pc", ID_pc, exp_q[0].pc);
      cmp("ID_instr", {32'd0, ID_instr}, {32'd0, exp_q[0].instr});
      if (id_ready && !flush && !reset) void'(exp_q.pop_front());
    end
  endtask

  // Monitor: mid-cycle, inputs and outputs are both stable.
  initial begin
    forever begin
      @(negedge clock);
      if (known) check_output();
    end
  end

  initial begin
    logic [63:0] base;
    logic [63:0] pc_ctr;

    apply_stimulus(1'b0, 64'd0, NOP, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 64'd0, NOP, 1'b0, 1'b0, 1'b1);

    base = 64'h0000_0000_8000_0000;
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, base + 64'(4 * i), 32'h1000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 64'd0, NOP, 1'b1, 1'b0, 1'b0);

    // Backpressure: 0x04 held while 0x08 parks in skid and 0x0C is refused.
    apply_stimulus(1'b1, base + 64'h00, 32'h2000_0000, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, base + 64'h04, 32'h2000_0004, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, base + 64'h08, 32'h2000_0008, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, base + 64'h0C, 32'h2000_000C, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, base + 64'h0C, 32'h2000_000C, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, base + 64'h0C, 32'h2000_000C, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 64'd0, NOP, 1'b1, 1'b0, 1'b0);

    // Flush with both entries full while fetch still offers a word.
    apply_stimulus(1'b1, 64'h100, 32'h3000_0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h104, 32'h3000_0004, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h108, 32'h3000_0008, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      apply_stimulus(1'b0, 64'd0, NOP, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with the skid occupied.
    apply_stimulus(1'b1, 64'h200, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h204, 32'h4000_0004, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h208, 32'h4000_0008, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      apply_stimulus(1'b0, 64'd0, NOP, 1'b1, 1'b0, 1'b0);

    pc_ctr = 64'h0000_0001_0000_0000;
    for (int i = 0; i < 10000; i++) begin
      apply_stimulus($urandom_range(0, 9) < 7, pc_ctr, $urandom,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0,
                     $urandom_range(0, 499) == 0);
      pc_ctr = pc_ctr + 64'd4;
    end

    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 64'd0, NOP, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    commit_pending();
    @(negedge clock);
    #1;
    cmp("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
